// File: rtl/pipeline_alu.sv
// pipeline_alu -- four-stage pipelined ALU with an internal register bank
// and a write-only data memory. One operation is issued every cycle that
// rst is low:
//   S1: read operands reg[rs1]/reg[rs2], latch rd/func/addr
//   S2: compute ALU result into Z_out
//   S3: write result back to reg[rd]
//   S4: store result to mem[addr]
//
// Ports:
//   clk1  - single clock, all state updates on rising edge
//   rst   - synchronous, active-high reset (discards in-flight operations)
//   rs1   - source register A index
//   rs2   - source register B index
//   rd    - destination register index
//   func  - operation code (0..15)
//   addr  - memory store address
//   Z_out - registered ALU result of stage 2
//
// Optional build macro:
//   ALU_FWD_EN - when defined, S1 operands are bypassed from the S2 result
//                and from the pending S3 write, so back-to-back dependent
//                operations see architecturally correct values.
module pipeline_alu #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] Z_out
);

    localparam int unsigned NREG = 1 << REG_AW;
    localparam int unsigned NMEM = 1 << MEM_AW;

    // S1 registers
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [REG_AW-1:0] rd1_q, rd1_d;
    logic [3:0]        func1_q, func1_d;
    logic [MEM_AW-1:0] addr1_q, addr1_d;
    logic              v1_q, v1_d;

    // S2 registers
    logic [DATA_W-1:0] z_q, z_d;
    logic [REG_AW-1:0] rd2_q, rd2_d;
    logic [MEM_AW-1:0] addr2_q, addr2_d;
    logic              v2_q, v2_d;

    // S3 registers
    logic [DATA_W-1:0] z3_q, z3_d;
    logic [MEM_AW-1:0] addr3_q, addr3_d;
    logic              v3_q, v3_d;

    // Register bank and data memory (memory is never reset)
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] mem    [NMEM];

    logic [DATA_W-1:0] alu_s2;

    function automatic logic [DATA_W-1:0] alu(
        input logic [3:0]        f,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = a;
            4'd4:    r = b;
            4'd5:    r = a & b;
            4'd6:    r = a | b;
            4'd7:    r = a ^ b;
            4'd8:    r = '0 - a;
            4'd9:    r = '0 - b;
            4'd10:   r = a >> 1;
            4'd11:   r = a << 1;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_s2 = alu(func1_q, a_q, b_q);
    assign Z_out  = z_q;

    // S1 operand selection. Without bypass, a read of a register being
    // written back on the same edge returns the old value.
    always_comb begin
`ifdef ALU_FWD_EN
        if (v1_q && (rs1 == rd1_q))      a_d = alu_s2;
        else if (v2_q && (rs1 == rd2_q)) a_d = z_q;
        else                             a_d = regs_q[rs1];
        if (v1_q && (rs2 == rd1_q))      b_d = alu_s2;
        else if (v2_q && (rs2 == rd2_q)) b_d = z_q;
        else                             b_d = regs_q[rs2];
`else
        a_d = regs_q[rs1];
        b_d = regs_q[rs2];
`endif
    end

    always_comb begin
        rd1_d   = rd;
        func1_d = func;
        addr1_d = addr;
        v1_d    = 1'b1;

        z_d     = alu_s2;
        rd2_d   = rd1_q;
        addr2_d = addr1_q;
        v2_d    = v1_q;

        z3_d    = z_q;
        addr3_d = addr2_q;
        v3_d    = v2_q;

        regs_d = regs_q;
        if (v2_q) regs_d[rd2_q] = z_q;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            rd1_q   <= '0;
            func1_q <= '0;
            addr1_q <= '0;
            v1_q    <= 1'b0;
            z_q     <= '0;
            rd2_q   <= '0;
            addr2_q <= '0;
            v2_q    <= 1'b0;
            z3_q    <= '0;
            addr3_q <= '0;
            v3_q    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            rd1_q   <= rd1_d;
            func1_q <= func1_d;
            addr1_q <= addr1_d;
            v1_q    <= v1_d;
            z_q     <= z_d;
            rd2_q   <= rd2_d;
            addr2_q <= addr2_d;
            v2_q    <= v2_d;
            z3_q    <= z3_d;
            addr3_q <= addr3_d;
            v3_q    <= v3_d;
            regs_q  <= regs_d;
        end
    end

    // S4 store; suppressed on the reset edge so memory keeps prior contents.
    always_ff @(posedge clk1) begin
        if (!rst && v3_q) mem[addr3_q] <= z3_q;
    end

endmodule

// File: tb/tb_pipeline_alu.sv
module tb_pipeline_alu;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  rs1  = '0;
    logic [3:0]  rs2  = '0;
    logic [3:0]  rd   = '0;
    logic [3:0]  func = 4'd3;
    logic [7:0]  addr = 8'hFF;
    logic [15:0] Z_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Scoreboard: one entry per issued operation
    bit          chk_q[$];
    logic [15:0] val_q[$];
    string       tag_q[$];

    pipeline_alu #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) dut (
        .clk1  (clk1),
        .rst   (rst),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .func  (func),
        .addr  (addr),
        .Z_out (Z_out)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one operation, clock it in, then compare the result of the
    // operation issued one edge earlier (now visible on Z_out).
    task automatic issue(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad,
                         input bit c, input logic [15:0] e, input string t);
        bit          pc;
        logic [15:0] pv;
        string       pt;
        rs1 = r1; rs2 = r2; rd = d; func = f; addr = ad;
        chk_q.push_back(c);
        val_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk1);
        #1;
        if (val_q.size() == 2) begin
            pc = chk_q.pop_front();
            pv = val_q.pop_front();
            pt = tag_q.pop_front();
            if (pc) check(pt, Z_out, pv);
        end
    endtask

    // Benign filler: reg0 = reg0 (stays 0), store to 0xFF
    task automatic idle();
        issue(4'd0, 4'd0, 4'd0, 4'd3, 8'hFF, 1'b0, 16'h0, "idle");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; func = 4'd3; addr = 8'hFF;
        @(posedge clk1);
        #1;
        rst = 1'b0;
        chk_q.delete();
        val_q.delete();
        tag_q.delete();
        check("rst_z", Z_out, 32'h0);
        check("rst_valid", {dut.v1_q, dut.v2_q, dut.v3_q}, 32'h0);
    endtask

    initial begin
        // Reset state
        do_reset();
        for (int i = 0; i < 16; i++) check("rst_reg", dut.regs_q[i], 32'(i));

        // Add, with writeback / store timing
        issue(4'd10, 4'd5, 4'd3, 4'd0, 8'h0A, 1'b1, 16'h000F, "add");
        idle();
        check("add_reg_not_yet", dut.regs_q[3], 32'd3);
        idle();
        check("add_reg", dut.regs_q[3], 32'd15);
        idle();
        check("add_mem", dut.mem[8'h0A], 32'd15);

        // Subtract and wrap
        do_reset();
        issue(4'd12, 4'd3, 4'd4, 4'd1, 8'h14, 1'b1, 16'h0009, "sub");
        issue(4'd2,  4'd3, 4'd6, 4'd1, 8'h15, 1'b1, 16'hFFFF, "sub_wrap");
        idle(); idle(); idle();
        check("sub_reg", dut.regs_q[4], 32'd9);
        check("sub_mem", dut.mem[8'h14], 32'd9);
        check("wrap_reg", dut.regs_q[6], 32'hFFFF);
        check("wrap_mem", dut.mem[8'h15], 32'hFFFF);

        // Back-to-back operation coverage
        do_reset();
        issue(4'd15, 4'd1,  4'd13, 4'd2,  8'h30, 1'b1, 16'h000F, "mul");
        issue(4'd12, 4'd10, 4'd13, 4'd5,  8'h31, 1'b1, 16'h0008, "and");
        issue(4'd12, 4'd10, 4'd13, 4'd7,  8'h32, 1'b1, 16'h0006, "xor");
        issue(4'd15, 4'd0,  4'd13, 4'd10, 8'h33, 1'b1, 16'h0007, "shr");
        issue(4'd15, 4'd9,  4'd13, 4'd12, 8'h34, 1'b1, 16'h0000, "f12");
        issue(4'd15, 4'd0,  4'd13, 4'd11, 8'h35, 1'b1, 16'h001E, "shl");
        issue(4'd1,  4'd0,  4'd13, 4'd8,  8'h36, 1'b1, 16'hFFFF, "neg_a");
        issue(4'd0,  4'd2,  4'd13, 4'd9,  8'h37, 1'b1, 16'hFFFE, "neg_b");
        issue(4'd9,  4'd2,  4'd13, 4'd3,  8'h38, 1'b1, 16'h0009, "pass_a");
        issue(4'd9,  4'd7,  4'd13, 4'd4,  8'h39, 1'b1, 16'h0007, "pass_b");
        issue(4'd12, 4'd10, 4'd13, 4'd6,  8'h3A, 1'b1, 16'h000E, "or");
        issue(4'd15, 4'd15, 4'd13, 4'd15, 8'h3B, 1'b1, 16'h0000, "f15");
        issue(4'd0,  4'd1,  4'd13, 4'd1,  8'h3C, 1'b1, 16'hFFFF, "sub_zero");
        idle(); idle(); idle();
        check("seq_last_mem", dut.mem[8'h3C], 32'hFFFF);

        // Dependency chain
        do_reset();
        issue(4'd1, 4'd2, 4'd5, 4'd0, 8'h40, 1'b1, 16'h0003, "dep_op1");
`ifdef ALU_FWD_EN
        issue(4'd5, 4'd5, 4'd6, 4'd0, 8'h41, 1'b1, 16'h0006, "dep_op2");
        issue(4'd5, 4'd1, 4'd7, 4'd0, 8'h42, 1'b1, 16'h0004, "dep_op3");
`else
        issue(4'd5, 4'd5, 4'd6, 4'd0, 8'h41, 1'b1, 16'h000A, "dep_op2");
        issue(4'd5, 4'd1, 4'd7, 4'd0, 8'h42, 1'b1, 16'h0006, "dep_op3");
`endif
        issue(4'd5, 4'd5, 4'd8, 4'd0, 8'h43, 1'b1, 16'h0006, "dep_op4");
        idle(); idle(); idle();

        // Reset mid-operation: in-flight sub must never reach reg or memory
        do_reset();
        issue(4'd10, 4'd5, 4'd3, 4'd1, 8'h0A, 1'b0, 16'h0, "mid");
        do_reset();
        check("mid_reg", dut.regs_q[3], 32'd3);
        idle(); idle(); idle();
        check("mid_reg_late", dut.regs_q[3], 32'd3);
        check("mid_mem", dut.mem[8'h0A], 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
